pow_block_loader: RTL
=====================

# pow_block_loader

Sequencer that sits directly downstream of the latency-aware read master in the PoW accelerator datapath. It launches a read of N fixed-size blocks, pops 32-bit words from the read master's show-ahead FIFO, and packs each group of WORDS_PER_BLOCK words into one wide block. Each block is presented to the Curl/PoW core over a valid/ready handshake. It reports busy/done to the CSR layer once every block has been accepted and all reads have returned.

## Interface
- DATAWIDTH, 32, width of one FIFO word
- ADDRESSWIDTH, 32, width of word address and read length
- WORDS_PER_BLOCK, 8, words per output block; power of two, ≥2
- BLKCNTWIDTH, 16, width of block count

- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- cmd_start  in  1  one-cycle start pulse; ignored while cmd_busy=1
- cmd_base  in  ADDRESSWIDTH  word address of the first block
- cmd_num_blocks  in  BLKCNTWIDTH  blocks to load; 0 is legal
- cmd_busy  out  1  high from the cycle after an accepted start until the done pulse
- cmd_done  out  1  one-cycle completion pulse
- rm_go  out  1  one-cycle go pulse to the read master
- rm_base  out  ADDRESSWIDTH  read base; registered copy of cmd_base
- rm_length  out  ADDRESSWIDTH  word count, cmd_num_blocks*WORDS_PER_BLOCK
- rm_done  in  1  read master all-reads-returned flag
- rm_read_buffer  out  1  FIFO pop
- rm_buffer_data  in  DATAWIDTH  FIFO head data (show-ahead)
- rm_data_available  in  1  FIFO non-empty
- blk_data  out  DATAWIDTH*WORDS_PER_BLOCK  assembled block; word 0 in the LSBs
- blk_valid  out  1  block valid
- blk_ready  in  1  consumer accepts the block
- blk_last  out  1  qualifies the final block of the command

## Operation
- States: IDLE, LAUNCH, SETTLE, FILL, PRESENT, DRAIN.
- **IDLE**
  - On cmd_start with cmd_num_blocks≠0: latch base, count and length, then go to LAUNCH.
  - On cmd_start with cmd_num_blocks=0: issue no go, pulse cmd_done next cycle, stay IDLE.
- **LAUNCH**: rm_go=1 for exactly one cycle, then go to SETTLE.
- **SETTLE**: one cycle. rm_done is not sampled here because the read master's length is still loading. Then go to FILL with word_idx=0.
- **FILL**
  - rm_read_buffer = rm_data_available; this is combinational and never asserted outside FILL.
  - Each pop writes rm_buffer_data into lane word_idx and increments word_idx.
  - Popping lane WORDS_PER_BLOCK-1 moves to PRESENT.
- **PRESENT**
  - blk_valid=1.
  - blk_data and blk_last hold stable until blk_ready.
  - On blk_valid&blk_ready: decrement blocks_left. If it was 1, go to DRAIN; otherwise go to FILL with word_idx=0.
- **DRAIN**: wait for rm_done=1, then pulse cmd_done and go to IDLE.
- blk_last = (blocks_left==1) in PRESENT.
- rm_length is computed in ADDRESSWIDTH bits, and overflow is the caller's responsibility.

## Timing
- Reset values: cmd_busy, cmd_done, rm_go, rm_read_buffer, blk_valid and blk_last are 0; rm_base, rm_length and blk_data are 0; state is IDLE.
- Reset mid-operation aborts immediately, with no done pulse. The read master shares the same reset.
- rm_go asserts one cycle after the accepted cmd_start.
- The earliest pop is 3 cycles after cmd_start (start→LAUNCH→SETTLE→FILL).
- blk_valid asserts the cycle after the last word of a block is popped. A block needs at least WORDS_PER_BLOCK+1 cycles.
- With blk_ready held high, no pop occurs in PRESENT cycles. FIFO backpressure is the only read throttle.
- A FIFO empty mid-block pauses FILL with no bubble in lane order.
- cmd_start in the same cycle as cmd_done is ignored; a new start must arrive in IDLE.
- cmd_done asserts the cycle after rm_done is seen in DRAIN. rm_done may already be high on entry, giving a 1-cycle DRAIN.

## Test plan
- **Single block:** base=0x100, num_blocks=1, FIFO words 0..7 available every cycle → rm_go 1 cycle after start; rm_length=8; blk_data[31:0]=0, blk_data[255:224]=7; blk_last=1; cmd_done follows rm_done.
- **Multi-block with backpressure:** num_blocks=3, blk_ready low for 5 cycles on block 2 → blk_data stable throughout; exactly 24 pops; blk_last only on block 3; one cmd_done.
- **Sparse FIFO:** rm_data_available toggling 1/0 → pops only when available; lane order preserved; no pop in SETTLE or PRESENT.
- **Zero blocks:** num_blocks=0 → no rm_go, no pops, cmd_done 1 cycle after start, cmd_busy stays 0.
- **Start while busy:** second cmd_start during FILL → ignored; rm_go pulses once; latched base and length are unchanged.
- **Mid-operation reset:** reset asserted in PRESENT → all outputs 0 asynchronously; no cmd_done; a subsequent start behaves like a fresh single-block load.

Source files
------------

// File: rtl/pow_block_loader_if.sv
// Block stream from the loader to the Curl/PoW core: one wide block per valid/ready beat.
interface pow_block_loader_if #(
  parameter int DATAWIDTH       = 32,
  parameter int WORDS_PER_BLOCK = 8
);
  logic [DATAWIDTH*WORDS_PER_BLOCK-1:0] blk_data;
  logic                                 blk_valid;
  logic                                 blk_ready;
  logic                                 blk_last;

  modport master (
    output blk_data,
    output blk_valid,
    output blk_last,
    input  blk_ready
  );

  modport slave (
    input  blk_data,
    input  blk_valid,
    input  blk_last,
    output blk_ready
  );
endinterface

// File: rtl/pow_block_loader.sv
// Launches a read of N blocks, pops show-ahead FIFO words into lanes and presents
// each packed block downstream; pulses cmd_done once all blocks are taken and reads returned.
module pow_block_loader #(
  parameter int DATAWIDTH       = 32,
  parameter int ADDRESSWIDTH    = 32,
  parameter int WORDS_PER_BLOCK = 8,
  parameter int BLKCNTWIDTH     = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cmd_start,
  input  logic [ADDRESSWIDTH-1:0] cmd_base,
  input  logic [BLKCNTWIDTH-1:0]  cmd_num_blocks,
  output logic                    cmd_busy,
  output logic                    cmd_done,
  output logic                    rm_go,
  output logic [ADDRESSWIDTH-1:0] rm_base,
  output logic [ADDRESSWIDTH-1:0] rm_length,
  input  logic                    rm_done,
  output logic                    rm_read_buffer,
  input  logic [DATAWIDTH-1:0]    rm_buffer_data,
  input  logic                    rm_data_available,
  pow_block_loader_if.master      blk
);
  localparam int              IDXW      = $clog2(WORDS_PER_BLOCK);
  localparam logic [IDXW-1:0] LAST_LANE = IDXW'(WORDS_PER_BLOCK - 1);

  typedef enum logic [2:0] {IDLE, LAUNCH, SETTLE, FILL, PRESENT, DRAIN} state_t;

  state_t                 state;
  logic [IDXW-1:0]        word_idx;
  logic [BLKCNTWIDTH-1:0] blocks_left;
  logic [DATAWIDTH-1:0]   lane [WORDS_PER_BLOCK];

  // Pop is combinational so a show-ahead word is consumed in the same cycle it is seen.
  assign rm_read_buffer = (state == FILL) && rm_data_available;

  for (genvar gi = 0; gi < WORDS_PER_BLOCK; gi++) begin : g_lane
    assign blk.blk_data[gi*DATAWIDTH +: DATAWIDTH] = lane[gi];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      word_idx      <= '0;
      blocks_left   <= '0;
      cmd_busy      <= 1'b0;
      cmd_done      <= 1'b0;
      rm_go         <= 1'b0;
      rm_base       <= '0;
      rm_length     <= '0;
      blk.blk_valid <= 1'b0;
      blk.blk_last  <= 1'b0;
      for (int i = 0; i < WORDS_PER_BLOCK; i++) lane[i] <= '0;
    end else begin
      cmd_done <= 1'b0;
      rm_go    <= 1'b0;
      case (state)
        IDLE: begin
          // A start coinciding with the done pulse belongs to the previous command.
          if (cmd_start && !cmd_done) begin
            if (cmd_num_blocks != '0) begin
              rm_base     <= cmd_base;
              rm_length   <= ADDRESSWIDTH'(cmd_num_blocks) << IDXW;
              blocks_left <= cmd_num_blocks;
              cmd_busy    <= 1'b1;
              rm_go       <= 1'b1;
              state       <= LAUNCH;
            end else begin
              cmd_done <= 1'b1;
            end
          end
        end
        LAUNCH: state <= SETTLE;
        SETTLE: begin
          // The read master is still loading its length; rm_done is meaningless here.
          word_idx <= '0;
          state    <= FILL;
        end
        FILL: begin
          if (rm_data_available) begin
            lane[word_idx] <= rm_buffer_data;
            word_idx       <= word_idx + IDXW'(1);
            if (word_idx == LAST_LANE) begin
              blk.blk_valid <= 1'b1;
              blk.blk_last  <= (blocks_left == BLKCNTWIDTH'(1));
              state         <= PRESENT;
            end
          end
        end
        PRESENT: begin
          if (blk.blk_ready) begin
            blk.blk_valid <= 1'b0;
            blk.blk_last  <= 1'b0;
            blocks_left   <= blocks_left - BLKCNTWIDTH'(1);
            word_idx      <= '0;
            state         <= (blocks_left == BLKCNTWIDTH'(1)) ? DRAIN : FILL;
          end
        end
        DRAIN: begin
          if (rm_done) begin
            cmd_done <= 1'b1;
            cmd_busy <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
